// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the read-adapter buffer
// occupancy encoding.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 32;

  // Output buffer occupancy; encoding doubles as the numeric word count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail output buffer for the FIFO read adapter. The head
// register is the presented word; the tail only holds a word captured while
// the head is stalled. A capture and a pop in state ONE replace the head on
// the same edge, so streaming never inserts a bubble.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output occ_e                  o_occ
);

  occ_e                  r_occ;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  // Occupancy FSM with registered valid and head/tail data movement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= OCC_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_occ   <= OCC_ONE;
            r_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_tail <= i_push_data;
            r_occ  <= OCC_TWO;
          end else if (i_pop) begin
            r_occ   <= OCC_EMPTY;
            r_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            r_occ  <= OCC_ONE;
          end
        end
        default: begin
          r_occ   <= OCC_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_occ   = r_occ;

`ifndef SYNTHESIS
  // The read-issue credit rule never lets a word land on a full buffer.
  a_no_capture_when_full: assert property (
    @(posedge clk) disable iff (rst) !(r_occ == OCC_TWO && i_push));
`endif

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side adapter for the fifo block: issues rd_en, captures data_out one
// cycle later into a 2-entry buffer, and presents a valid/ready stream at
// one word per cycle.
// Optional feature macro: FIFO_RD_ADAPTER_STATS_EN adds saturating
// accepted-beat and back-pressure counters on stat_words / stat_stalls.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_FIFO_WIDTH,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_words,
  output logic [STAT_WIDTH-1:0] stat_stalls
`endif
);

  logic       r_inflight;
  logic       w_pop;
  occ_e       w_occ;
  logic [2:0] w_lvl;

  assign w_pop = m_valid && m_ready;

  // Projected occupancy after this edge; crediting the pop keeps a read
  // issued every cycle while the consumer drains.
  assign w_lvl = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign fifo_rd_en = !rst && !fifo_empty && (w_lvl < 3'd2);

  // A read issued this cycle returns data on the next one.
  always_ff @(posedge clk) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= fifo_rd_en;
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .o_occ       (w_occ)
  );

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [STAT_WIDTH-1:0] r_words;
  logic [STAT_WIDTH-1:0] r_stalls;

  // Saturating beat and stall counters; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_words  <= '0;
      r_stalls <= '0;
    end else begin
      if (w_pop && (r_words != '1))
        r_words <= r_words + 1'b1;
      if (m_valid && !m_ready && (r_stalls != '1))
        r_stalls <= r_stalls + 1'b1;
    end
  end

  assign stat_words  = r_words;
  assign stat_stalls = r_stalls;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: a cycle table covering back-pressure
// and the empty boundary, plus hand sequences for streaming, toggling ready,
// reset mid-stream and (with FIFO_RD_ADAPTER_STATS_EN) the counters.
module tb_fifo_rd_adapter;

  localparam int DW = 8;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  localparam int SW = 4;
`else
  localparam int SW = 32;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [SW-1:0] stat_words;
  logic [SW-1:0] stat_stalls;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_rd_adapter #(
    .DATA_WIDTH (DW),
    .STAT_WIDTH (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  // FIFO model: registered data_out one cycle after rd_en.
  logic [DW-1:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rp[7:0]];
      rp        <= rp + 1;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wp[7:0]] = d;
    wp = wp + 1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          wr;
    logic [DW-1:0] wd;
    logic          exp_rd;
    logic          exp_v;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [4:0]    pat;
    logic          stalled;
    logic [DW-1:0] held;
    int            idx;

    // rst rdy wr wd   | rd  v  data
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

    // Back-pressure with 5 queued words, then a lone word into an empty FIFO.
    rst = 1'b1;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    tick;
    for (int i = 0; i < 17; i++) begin
      rst     = tbl[i].rst;
      m_ready = tbl[i].rdy;
      if (tbl[i].wr) push(tbl[i].wd);
      #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v || tbl[i].rst)
        chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(tbl[i].exp_d));
      tick;
    end

    // Streaming: 32 preloaded words, ready high from reset release.
    rst = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 32; i++) push(DW'(i));
    tick;
    rst = 1'b0;
    for (int c = 0; c < 35; c++) begin
      #1;
      chk("stream_rd_vs_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      chk($sformatf("stream_valid_c%0d", c), 32'(m_valid), 32'((c >= 2 && c <= 33) ? 1 : 0));
      if (c >= 2 && c <= 33)
        chk($sformatf("stream_data_c%0d", c), 32'(m_data), 32'(c - 1));
      tick;
    end

    // Toggling ready 1,0,1,1,0 over 0xA0..0xA9.
    rst = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) push(DW'(8'hA0 + i));
    rst = 1'b0;
    pat = 5'b01101;
    stalled = 1'b0;
    held = '0;
    idx = 0;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      m_ready = pat[c % 5];
      #1;
      if (stalled) begin
        chk("toggle_hold_valid", 32'(m_valid), 32'd1);
        chk("toggle_hold_data", 32'(m_data), 32'(held));
      end
      if (m_valid && m_ready) begin
        chk("toggle_order", 32'(m_data), 32'(8'hA0 + idx));
        idx++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      tick;
    end
    chk("toggle_count", 32'(idx), 32'd10);
    m_ready = 1'b1;
    tick;
    #1;
    chk("toggle_drained", 32'(m_valid), 32'd0);

    // Reset with one word buffered and one in flight (occ=TWO plus a read
    // in flight never coexist); both words are dropped.
    rst = 1'b1;
    m_ready = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) push(DW'(8'h10 + i));
    rst = 1'b0;
    #1;
    chk("mid_rd_c0", 32'(fifo_rd_en), 32'd1);
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rd_low_in_rst", 32'(fifo_rd_en), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("mid_valid_after_rst", 32'(m_valid), 32'd0);
    chk("mid_data_after_rst", 32'(m_data), 32'd0);
    chk("mid_rd_after_rst", 32'(fifo_rd_en), 32'd1);
    tick;
    m_ready = 1'b1;
    #1;
    chk("mid_valid_c4", 32'(m_valid), 32'd0);
    tick;
    #1;
    chk("mid_valid_c5", 32'(m_valid), 32'd1);
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      #1;
      if (m_valid) begin
        chk("mid_order", 32'(m_data), 32'(8'h12 + idx));
        idx++;
      end
      tick;
    end
    chk("mid_count", 32'(idx), 32'd8);

`ifdef FIFO_RD_ADAPTER_STATS_EN
    // Counters: 3 stall cycles and 8 pops, then saturation at 2**SW-1.
    rst = 1'b1;
    m_ready = 1'b0;
    tick;
    #1;
    chk("stat_words_rst", 32'(stat_words), 32'd0);
    chk("stat_stalls_rst", 32'(stat_stalls), 32'd0);
    for (int i = 0; i < 8; i++) push(DW'(8'h30 + i));
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick;
    chk("stat_words_8", 32'(stat_words), 32'd8);
    chk("stat_stalls_3", 32'(stat_stalls), 32'd3);
    for (int i = 0; i < 8; i++) push(DW'(8'h40 + i));
    for (int c = 0; c < 14; c++) tick;
    chk("stat_words_sat", 32'(stat_words), 32'((1 << SW) - 1));
    chk("stat_stalls_keep", 32'(stat_stalls), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
